serial_adder_ctrl: RTL and testbench

//   Bit-serial N-bit adder controller. Sequences one shared 1-bit adder

---
 rtl/serial_adder_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared 1-bit slice (two half adders + OR)
// is stepped LSB-first over WIDTH cycles under a start/busy/done handshake.

module halfadder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// Handshake: start is sampled only while IDLE; busy is high for the WIDTH
// RUN cycles; done pulses for one cycle with sum/cout valid from that cycle.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic ha0_s, ha0_c, ha1_c, slice_sum, slice_cout;

    halfadder u_ha0 (.x(a_sr_q[0]), .y(b_sr_q[0]), .s(ha0_s), .c(ha0_c));
    halfadder u_ha1 (.x(ha0_s), .y(carry_q), .s(slice_sum), .c(ha1_c));
    assign slice_cout = ha0_c | ha1_c;

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        // Status flags follow the state one cycle later so both are pure flops.
        busy_d  = (state_q == S_RUN);
        done_d  = (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    res_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d   = (res_q >> 1) | (WIDTH'(slice_sum) << (WIDTH - 1));
                carry_d = slice_cout;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                sum_d   = res_q;
                cout_d  = carry_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH = 1, 8 and 32: directed handshake cases
// on the 8-bit instance, then concurrent random traffic on all three.

module tb_serial_adder_ctrl;
    logic clk;
    logic rst_n;

    logic        start_v [3];
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    logic        busy_v [3];
    logic        done_v [3];
    logic [31:0] sum_v [3];
    logic        cout_v [3];
    logic        prev_done [3];
    int          done_cnt [3];

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [32:0] exp_q2[$];

    int checks;
    int failures;

    logic [0:0]  sum_w1;
    logic [7:0]  sum_w8;
    logic [31:0] sum_w32;
    logic        busy_w1, busy_w8, busy_w32;
    logic        done_w1, done_w8, done_w32;
    logic        cout_w1, cout_w8, cout_w32;
    logic [1:0]  st_w1, st_w8, st_w32;

    serial_adder_ctrl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .a(a_v[0][0:0]), .b(b_v[0][0:0]),
        .busy(busy_w1), .done(done_w1), .sum(sum_w1), .cout(cout_w1),
        .dbg_state(st_w1)
    );
    serial_adder_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]),
        .busy(busy_w8), .done(done_w8), .sum(sum_w8), .cout(cout_w8),
        .dbg_state(st_w8)
    );
    serial_adder_ctrl #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .a(a_v[2]), .b(b_v[2]),
        .busy(busy_w32), .done(done_w32), .sum(sum_w32), .cout(cout_w32),
        .dbg_state(st_w32)
    );

    always_comb begin
        busy_v[0] = busy_w1;  done_v[0] = done_w1;  cout_v[0] = cout_w1;
        busy_v[1] = busy_w8;  done_v[1] = done_w8;  cout_v[1] = cout_w8;
        busy_v[2] = busy_w32; done_v[2] = done_w32; cout_v[2] = cout_w32;
        sum_v[0]  = {31'b0, sum_w1};
        sum_v[1]  = {24'b0, sum_w8};
        sum_v[2]  = sum_w32;
    end

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int width_of(int k);
        return (k == 0) ? 1 : (k == 1) ? 8 : 32;
    endfunction

    function automatic logic [32:0] ref_add(int k, logic [31:0] x, logic [31:0] y);
        logic [32:0] m;
        m = (33'd1 << width_of(k)) - 33'd1;
        return ({1'b0, x} & m) + ({1'b0, y} & m);
    endfunction

    function automatic logic [32:0] dut_result(int k);
        return ({32'b0, cout_v[k]} << width_of(k)) | {1'b0, sum_v[k]};
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic push_exp(int k, logic [32:0] v);
        case (k)
            0: exp_q0.push_back(v);
            1: exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    task automatic pop_exp(int k, output logic ok, output logic [32:0] v);
        ok = 1'b0;
        v  = '0;
        case (k)
            0: if (exp_q0.size() > 0) begin ok = 1'b1; v = exp_q0.pop_front(); end
            1: if (exp_q1.size() > 0) begin ok = 1'b1; v = exp_q1.pop_front(); end
            default: if (exp_q2.size() > 0) begin ok = 1'b1; v = exp_q2.pop_front(); end
        endcase
    endtask

    function automatic int qsize(int k);
        return (k == 0) ? exp_q0.size() : (k == 1) ? exp_q1.size() : exp_q2.size();
    endfunction

    task automatic chk(string name, logic [32:0] got, logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic check_done(int k);
        logic        ok;
        logic [32:0] e;
        chk($sformatf("busy_done_overlap_k%0d", k), {32'b0, busy_v[k]}, 33'd0);
        chk($sformatf("done_width_k%0d", k), {32'b0, prev_done[k]}, 33'd0);
        pop_exp(k, ok, e);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done_k%0d got=%0h exp=none", k, dut_result(k));
        end else begin
            chk($sformatf("result_k%0d", k), dut_result(k), e);
        end
        done_cnt[k]++;
    endtask

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            if (done_v[k]) check_done(k);
            prev_done[k] = done_v[k];
        end
    end

    // ---------------- driver ----------------
    // Presents one operation; returns just after the edge that accepts it,
    // then scrambles the operand inputs so late changes would be visible.
    task automatic issue(int k, logic [31:0] x, logic [31:0] y);
        @(negedge clk);
        a_v[k]     = x;
        b_v[k]     = y;
        start_v[k] = 1'b1;
        push_exp(k, ref_add(k, x, y));
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        a_v[k]     = $urandom;
        b_v[k]     = $urandom;
    endtask

    // Ends just after the edge that raises done for the last issued op.
    task automatic wait_op(int k);
        repeat (width_of(k) + 1) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, bc, d0;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_v[k]   = 1'b0;
            a_v[k]       = '0;
            b_v[k]       = '0;
            prev_done[k] = 1'b0;
            done_cnt[k]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_busy_k%0d", k), {32'b0, busy_v[k]}, 33'd0);
            chk($sformatf("reset_done_k%0d", k), {32'b0, done_v[k]}, 33'd0);
            chk($sformatf("reset_result_k%0d", k), dut_result(k), 33'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Latency and busy window for a single operation.
        issue(1, 32'h5A, 32'h3C);
        n  = 0;
        bc = 0;
        while (!done_v[1] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (busy_v[1]) bc++;
        end
        chk("t1_latency", n, 9);
        chk("t1_busy_cycles", bc, 8);
        chk("t1_sum", {1'b0, sum_v[1]}, 33'h96);
        chk("t1_cout", {32'b0, cout_v[1]}, 33'd0);

        // Carry-out corner cases.
        issue(1, 32'hFF, 32'h01);
        wait_op(1);
        chk("t2_ff01_sum", {1'b0, sum_v[1]}, 33'h00);
        chk("t2_ff01_cout", {32'b0, cout_v[1]}, 33'd1);
        issue(1, 32'hFF, 32'hFF);
        wait_op(1);
        chk("t2_ffff_sum", {1'b0, sum_v[1]}, 33'hFE);
        chk("t2_ffff_cout", {32'b0, cout_v[1]}, 33'd1);

        // start held for 20 edges: accepted at the first edge and 10 later.
        repeat (2) @(posedge clk);
        d0 = done_cnt[1];
        @(negedge clk);
        a_v[1]     = 32'h10;
        b_v[1]     = 32'h20;
        start_v[1] = 1'b1;
        push_exp(1, ref_add(1, 32'h10, 32'h20));
        push_exp(1, ref_add(1, 32'h10, 32'h20));
        repeat (20) @(negedge clk);
        start_v[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t3_done_count", done_cnt[1] - d0, 2);
        chk("t3_queue_empty", qsize(1), 0);
        chk("t3_sum", {1'b0, sum_v[1]}, 33'h30);

        // Operand change and extra start pulse mid-RUN are ignored.
        d0 = done_cnt[1];
        issue(1, 32'hC3, 32'h5E);
        repeat (3) @(negedge clk);
        a_v[1]     = $urandom;
        b_v[1]     = $urandom;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("t4_done_count", done_cnt[1] - d0, 1);
        chk("t4_sum", {1'b0, sum_v[1]}, 33'h21);
        chk("t4_cout", {32'b0, cout_v[1]}, 33'd1);

        // Asynchronous reset in the middle of RUN.
        issue(1, 32'h7F, 32'h7F);
        repeat (4) @(posedge clk);
        #3;
        chk("t5_busy_before_reset", {32'b0, busy_v[1]}, 33'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", {32'b0, busy_v[1]}, 33'd0);
        chk("t5_done", {32'b0, done_v[1]}, 33'd0);
        chk("t5_sum", {1'b0, sum_v[1]}, 33'd0);
        chk("t5_cout", {32'b0, cout_v[1]}, 33'd0);
        exp_q1.delete();
        d0 = done_cnt[1];
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("t5_no_done_after_reset", done_cnt[1] - d0, 0);

        // Random traffic on all three widths concurrently.
        fork
            for (int i = 0; i < 1000; i++) begin
                issue(0, $urandom, $urandom);
                wait_op(0);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            for (int i = 0; i < 1000; i++) begin
                issue(1, $urandom, $urandom);
                wait_op(1);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            for (int i = 0; i < 1000; i++) begin
                issue(2, $urandom, $urandom);
                wait_op(2);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
        join
        repeat (40) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("final_queue_empty_k%0d", k), qsize(k), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
